// File: rtl/dac_intf_mc_if.sv
// Bus bundle between the DAC source interface and its neighbours: DMA, TX accelerator FIFO
// port, DAC unpacker and the control/status signals.
interface dac_intf_mc_if #(
    parameter int unsigned IQ_DATA_WIDTH = 16,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned FIFO_DEPTH    = 32,
    parameter int unsigned CNT_WIDTH     = 16
);
    localparam int unsigned DW = NUM_CH * 2 * IQ_DATA_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0]              dma_data;
    logic                       dma_valid;
    logic                       dma_ready;
    logic [DW-1:0]              dac_data;
    logic                       dac_valid;
    logic                       dac_ready;
    logic                       src_sel;
    logic [NUM_CH-1:0]          ant_mask;
    logic [AW:0]                prefill_thr;
    logic [2*IQ_DATA_WIDTH-1:0] data_from_acc;
    logic                       data_valid_from_acc;
    logic                       fulln_to_acc;
    logic [AW:0]                fifo_count;
    logic [CNT_WIDTH-1:0]       underrun_cnt;
    logic                       underrun_clr;
    logic [1:0]                 state_o;

    modport slave (
        input  dma_data, dma_valid, dac_ready, src_sel, ant_mask, prefill_thr,
               data_from_acc, data_valid_from_acc, underrun_clr,
        output dma_ready, dac_data, dac_valid, fulln_to_acc, fifo_count, underrun_cnt, state_o
    );

    modport master (
        output dma_data, dma_valid, dac_ready, src_sel, ant_mask, prefill_thr,
               data_from_acc, data_valid_from_acc, underrun_clr,
        input  dma_ready, dac_data, dac_valid, fulln_to_acc, fifo_count, underrun_cnt, state_o
    );
endinterface

// File: rtl/dac_intf_mc.sv
// N-channel DAC source interface: DMA pass-through or accelerator FIFO with prefill, flush on
// mode switch, per-channel sample replication under ant_mask and a saturating underrun counter.
module dac_intf_mc #(
    parameter int unsigned IQ_DATA_WIDTH = 16,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned FIFO_DEPTH    = 32,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input logic          dac_clk,
    input logic          dac_rst,
    dac_intf_mc_if.slave bus_io
);
    localparam int unsigned SW = 2 * IQ_DATA_WIDTH;
    localparam int unsigned DW = NUM_CH * SW;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] StDma     = 2'd0;
    localparam logic [1:0] StPrefill = 2'd1;
    localparam logic [1:0] StStream  = 2'd2;
    localparam logic [1:0] StFlush   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [SW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic [DW-1:0]        dac_data_q, dac_data_d;
    logic [CNT_WIDTH-1:0] under_q, under_d;
    logic                 full, empty, fulln, push, pop, underrun;
    logic [AW:0]          thr_eff;
    logic [SW-1:0]        head;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign thr_eff = (bus_io.prefill_thr == '0) ? (AW+1)'(1) : bus_io.prefill_thr;
    assign fulln   = !dac_rst && !full && (state_q != StFlush);
    assign push    = bus_io.data_valid_from_acc && fulln;

    always_comb begin
        pop      = 1'b0;
        underrun = 1'b0;
        case (state_q)
            StStream: begin
                if (bus_io.dac_ready) begin
                    pop      = !empty;
                    underrun = empty;
                end
            end
            StFlush: pop = !empty;
            default: ;
        endcase
    end

    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StDma:     if (bus_io.src_sel) state_d = StPrefill;
            StPrefill: begin
                if (!bus_io.src_sel)         state_d = StFlush;
                else if (count_q >= thr_eff) state_d = StStream;
            end
            StStream:  if (!bus_io.src_sel) state_d = StFlush;
            // No writes during flush, so count_d reaching zero means the last entry left.
            StFlush:   if (count_d == '0) state_d = StDma;
            default:   state_d = StDma;
        endcase
    end

    // Mask is applied at load time so a mask change only affects the next loaded word.
    always_comb begin
        dac_data_d = dac_data_q;
        if (state_q != StStream) begin
            dac_data_d = '0;
        end else if (bus_io.dac_ready) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                dac_data_d[c*SW +: SW] = (pop && bus_io.ant_mask[c]) ? head : '0;
            end
        end
    end

    always_comb begin
        under_d = under_q;
        if (bus_io.underrun_clr)                 under_d = '0;
        else if (underrun && (under_q != '1))    under_d = under_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state_q    <= StDma;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dac_data_q <= '0;
            under_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dac_data_q <= dac_data_d;
            under_q    <= under_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge dac_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_io.data_from_acc;
    end

    always_comb begin
        case (state_q)
            StDma:   bus_io.dac_data = bus_io.dma_data;
            StFlush: bus_io.dac_data = '0;
            default: bus_io.dac_data = dac_data_q;
        endcase
    end

    assign bus_io.dac_valid    = !dac_rst && ((state_q == StDma) ? bus_io.dma_valid : 1'b1);
    assign bus_io.dma_ready    = !dac_rst && (state_q == StDma) && bus_io.dac_ready;
    assign bus_io.fulln_to_acc = fulln;
    assign bus_io.fifo_count   = count_q;
    assign bus_io.underrun_cnt = under_q;
    assign bus_io.state_o      = state_q;
endmodule

// File: tb/tb_dac_intf_mc.sv
// Directed bench for dac_intf_mc: queue-based model checked every cycle, plus literal spot checks.
module tb_dac_intf_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dac_intf_mc_if #(.CNT_WIDTH(16)) bus ();
    dac_intf_mc_if #(.CNT_WIDTH(4))  bus4 ();

    dac_intf_mc #(.CNT_WIDTH(16)) u_dut (.dac_clk(clk), .dac_rst(rst), .bus_io(bus));
    dac_intf_mc #(.CNT_WIDTH(4))  u_dut4 (.dac_clk(clk), .dac_rst(rst), .bus_io(bus4));

    assign bus4.dma_data            = bus.dma_data;
    assign bus4.dma_valid           = bus.dma_valid;
    assign bus4.dac_ready           = bus.dac_ready;
    assign bus4.src_sel             = bus.src_sel;
    assign bus4.ant_mask            = bus.ant_mask;
    assign bus4.prefill_thr         = bus.prefill_thr;
    assign bus4.data_from_acc       = bus.data_from_acc;
    assign bus4.data_valid_from_acc = bus.data_valid_from_acc;
    assign bus4.underrun_clr        = bus.underrun_clr;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 DMA, 1 PREFILL, 2 STREAM, 3 FLUSH; FIFO is a plain queue.
    int          m_state = 0;
    logic [31:0] m_q[$];
    logic [63:0] m_data = '0;
    int          m_under = 0;
    int          m_under4 = 0;
    int          m_sz, m_nxt, m_thr;
    bit          m_wr, m_ur;
    logic [31:0] m_s;

    function automatic logic [63:0] rep(input logic [31:0] s, input logic [1:0] m);
        rep = {m[1] ? s : 32'h0, m[0] ? s : 32'h0};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_q.delete();
            m_data = '0;
            m_under = 0;
            m_under4 = 0;
        end else begin
            m_sz  = m_q.size();
            m_wr  = bus.data_valid_from_acc && (m_sz < 32) && (m_state != 3);
            m_ur  = 1'b0;
            m_nxt = m_state;
            m_thr = (bus.prefill_thr == 0) ? 1 : int'(bus.prefill_thr);
            case (m_state)
                0: begin
                    m_data = '0;
                    if (bus.src_sel) m_nxt = 1;
                end
                1: begin
                    m_data = '0;
                    if (!bus.src_sel) m_nxt = 3;
                    else if (m_sz >= m_thr) m_nxt = 2;
                end
                2: begin
                    if (bus.dac_ready) begin
                        if (m_sz > 0) begin
                            m_s = m_q.pop_front();
                            m_data = rep(m_s, bus.ant_mask);
                        end else begin
                            m_data = '0;
                            m_ur = 1'b1;
                        end
                    end
                    if (!bus.src_sel) m_nxt = 3;
                end
                default: begin
                    m_data = '0;
                    if (m_sz > 0) m_s = m_q.pop_front();
                    if (m_q.size() == 0) m_nxt = 0;
                end
            endcase
            if (m_wr) m_q.push_back(bus.data_from_acc);
            if (bus.underrun_clr) begin
                m_under = 0;
                m_under4 = 0;
            end else if (m_ur) begin
                if (m_under < 65535) m_under++;
                if (m_under4 < 15) m_under4++;
            end
            m_state = m_nxt;
        end
    end

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            logic [63:0] e_data;
            logic        e_valid, e_ready, e_fulln;
            e_valid = !rst && ((m_state == 0) ? bus.dma_valid : 1'b1);
            e_ready = !rst && (m_state == 0) && bus.dac_ready;
            e_fulln = !rst && (m_q.size() < 32) && (m_state != 3);
            e_data  = (m_state == 0) ? bus.dma_data : ((m_state == 3) ? 64'h0 : m_data);
            cmp("dac_data", bus.dac_data, e_data);
            cmp("dac_valid", 64'(bus.dac_valid), 64'(e_valid));
            cmp("dma_ready", 64'(bus.dma_ready), 64'(e_ready));
            cmp("fulln", 64'(bus.fulln_to_acc), 64'(e_fulln));
            cmp("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
            cmp("state", 64'(bus.state_o), 64'(m_state));
            cmp("underrun", 64'(bus.underrun_cnt), 64'(m_under));
            cmp("c4_underrun", 64'(bus4.underrun_cnt), 64'(m_under4));
            cmp("c4_dac_data", bus4.dac_data, e_data);
            cmp("c4_flags", {61'h0, bus4.dac_valid, bus4.dma_ready, bus4.fulln_to_acc},
                {61'h0, e_valid, e_ready, e_fulln});
            cmp("c4_count_state", {56'h0, bus4.fifo_count, bus4.state_o},
                {56'h0, 6'(m_q.size()), 2'(m_state)});
        end
    end

    task automatic nc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.dma_data = '0;
        bus.dma_valid = 1'b0;
        bus.dac_ready = 1'b0;
        bus.src_sel = 1'b0;
        bus.ant_mask = 2'b11;
        bus.prefill_thr = 6'd8;
        bus.data_from_acc = '0;
        bus.data_valid_from_acc = 1'b0;
        bus.underrun_clr = 1'b0;
        nc(); nc();
        chk_en = 1'b1;
        #3;
        cmp("rst_state", 64'(bus.state_o), 64'd0);
        cmp("rst_count", 64'(bus.fifo_count), 64'd0);
        cmp("rst_valid_fulln", {62'h0, bus.dac_valid, bus.fulln_to_acc}, 64'd0);
        nc(); rst = 1'b0;

        // DMA pass-through ramp
        bus.dac_ready = 1'b1;
        bus.dma_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nc();
            bus.dma_data = 64'(i) * 64'h0001_0001_0001_0001;
        end
        #3;
        cmp("dma_pass", bus.dac_data, 64'h0007_0007_0007_0007);
        cmp("dma_ready", 64'(bus.dma_ready), 64'd1);

        // Prefill with threshold 8
        nc(); bus.dma_valid = 1'b0; bus.dac_ready = 1'b0; bus.src_sel = 1'b1;
        for (int k = 0; k < 7; k++) begin
            nc(); bus.data_valid_from_acc = 1'b1; bus.data_from_acc = 32'hA000_0000 + 32'(k);
        end
        nc(); bus.data_valid_from_acc = 1'b0;
        #3;
        cmp("prefill_state", 64'(bus.state_o), 64'd1);
        cmp("prefill_count", 64'(bus.fifo_count), 64'd7);
        cmp("prefill_data", bus.dac_data, 64'd0);
        nc(); bus.data_valid_from_acc = 1'b1; bus.data_from_acc = 32'hA000_0007;
        nc(); bus.data_valid_from_acc = 1'b0;
        #3 cmp("prefill_8", 64'(bus.state_o), 64'd1);
        nc(); bus.dac_ready = 1'b1;
        #3 cmp("stream_entry", 64'(bus.state_o), 64'd2);
        nc();
        #3 cmp("first_pop", bus.dac_data, 64'hA000_0000_A000_0000);
        repeat (7) nc();
        bus.dac_ready = 1'b0;
        #3 cmp("last_pop", bus.dac_data, 64'hA000_0007_A000_0007);

        // Antenna mask
        nc(); bus.data_valid_from_acc = 1'b1; bus.data_from_acc = 32'h1234_ABCD;
        bus.ant_mask = 2'b10;
        nc(); bus.data_valid_from_acc = 1'b0; bus.dac_ready = 1'b1;
        nc(); bus.dac_ready = 1'b0;
        #3 cmp("mask_10", bus.dac_data, 64'h1234_ABCD_0000_0000);
        bus.ant_mask = 2'b11; bus.data_valid_from_acc = 1'b1;
        nc(); bus.data_valid_from_acc = 1'b0; bus.dac_ready = 1'b1;
        nc(); bus.dac_ready = 1'b0;
        #3 cmp("mask_11", bus.dac_data, 64'h1234_ABCD_1234_ABCD);

        // Underrun counting, clear and saturation
        nc(); bus.dac_ready = 1'b1;
        repeat (5) nc();
        bus.dac_ready = 1'b0;
        #3;
        cmp("underrun_5", 64'(bus.underrun_cnt), 64'd5);
        cmp("underrun_data", bus.dac_data, 64'd0);
        nc(); bus.underrun_clr = 1'b1;
        nc(); bus.underrun_clr = 1'b0;
        #3 cmp("underrun_clr", 64'(bus.underrun_cnt), 64'd0);
        bus.dac_ready = 1'b1;
        repeat (20) nc();
        #3;
        cmp("sat_4bit", 64'(bus4.underrun_cnt), 64'd15);
        cmp("count_20", 64'(bus.underrun_cnt), 64'd20);
        bus.underrun_clr = 1'b1;
        nc(); bus.underrun_clr = 1'b0; bus.dac_ready = 1'b0;
        #3 cmp("clr_priority", 64'(bus.underrun_cnt), 64'd0);

        // Fill to full, then concurrent write/pop across pointer wrap
        nc(); bus.data_valid_from_acc = 1'b1;
        for (int k = 0; k < 33; k++) begin
            bus.data_from_acc = 32'hB000_0000 + 32'(k);
            nc();
        end
        bus.data_valid_from_acc = 1'b0;
        #3;
        cmp("full_count", 64'(bus.fifo_count), 64'd32);
        cmp("full_fulln", 64'(bus.fulln_to_acc), 64'd0);
        bus.data_valid_from_acc = 1'b1; bus.dac_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            bus.data_from_acc = 32'hC000_0000 + 32'(k);
            nc();
        end
        bus.data_valid_from_acc = 1'b0; bus.dac_ready = 1'b0;
        #3 cmp("wrap_count", 64'(bus.fifo_count), 64'd31);

        // Drain to 10 entries, then switch to DMA through FLUSH
        bus.dac_ready = 1'b1;
        repeat (21) nc();
        bus.dac_ready = 1'b0;
        #3 cmp("pre_flush_count", 64'(bus.fifo_count), 64'd10);
        bus.src_sel = 1'b0;
        nc(); bus.data_valid_from_acc = 1'b1; bus.data_from_acc = 32'hDEAD_BEEF;
        #3;
        cmp("flush_state", 64'(bus.state_o), 64'd3);
        cmp("flush_fulln", 64'(bus.fulln_to_acc), 64'd0);
        nc(); bus.src_sel = 1'b1;
        repeat (8) nc();
        #3 cmp("flush_10th", 64'(bus.state_o), 64'd3);
        nc();
        #3;
        cmp("flush_done", 64'(bus.state_o), 64'd0);
        cmp("flush_empty", 64'(bus.fifo_count), 64'd0);
        bus.data_valid_from_acc = 1'b0;

        // Reset in the middle of streaming
        bus.prefill_thr = 6'd0;
        for (int k = 0; k < 5; k++) begin
            nc(); bus.data_valid_from_acc = 1'b1; bus.data_from_acc = 32'hD000_0000 + 32'(k);
        end
        nc(); bus.data_valid_from_acc = 1'b0; bus.dac_ready = 1'b1;
        repeat (8) nc();
        bus.dac_ready = 1'b0; bus.data_valid_from_acc = 1'b1;
        repeat (3) nc();
        bus.data_valid_from_acc = 1'b0; rst = 1'b1;
        nc(); nc();
        #3;
        cmp("mid_rst_count", 64'(bus.fifo_count), 64'd0);
        cmp("mid_rst_state", 64'(bus.state_o), 64'd0);
        cmp("mid_rst_under", 64'(bus.underrun_cnt), 64'd0);
        rst = 1'b0; bus.src_sel = 1'b0;
        nc(); nc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
